// File: rtl/shift_seq_reg.sv
// Universal shift register with serial/zero/rotate/arithmetic fill and a
// counter-sequenced burst mode that raises busy while running and pulses done at the end.
module shift_seq_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       S,
  input  logic [1:0]       M,
  input  logic             IL,
  input  logic             IR,
  input  logic [WIDTH-1:0] In,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] out,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [1:0]         m_q, m_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               so_q, so_d;
  logic               done_q, done_d;

  logic               stepLeft;
  logic [1:0]         stepMode;
  logic               fillBit;
  logic [WIDTH-1:0]   shiftVal;
  logic               shiftSo;

  // A burst steps with the direction and mode latched at start; otherwise the live inputs apply.
  always_comb begin
    stepLeft = (state_q == RUN) ? dir_q : S[0];
    stepMode = (state_q == RUN) ? m_q : M;
    fillBit  = 1'b0;
    case (stepMode)
      2'b00:   fillBit = stepLeft ? IL : IR;
      2'b01:   fillBit = 1'b0;
      2'b10:   fillBit = stepLeft ? out_q[WIDTH-1] : out_q[0];
      default: fillBit = stepLeft ? 1'b0 : out_q[WIDTH-1];
    endcase
    shiftVal = stepLeft ? {out_q[WIDTH-2:0], fillBit} : {fillBit, out_q[WIDTH-1:1]};
    shiftSo  = stepLeft ? out_q[WIDTH-1] : out_q[0];
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    m_d     = m_q;
    out_d   = out_q;
    so_d    = so_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (S)
          2'b01: out_d = In;
          2'b10, 2'b11: begin
            if (start) begin
              dir_d = S[0];
              m_d   = M;
              if (cnt != '0) begin
                rem_d   = cnt;
                state_d = RUN;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              out_d = shiftVal;
              so_d  = shiftSo;
            end
          end
          default: ;
        endcase
      end
      default: begin
        out_d = shiftVal;
        so_d  = shiftSo;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      m_q     <= 2'b00;
      out_q   <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      m_q     <= m_d;
      out_q   <= out_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign so   = so_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed test of shift_seq_reg: reset, load/hold, immediate fill modes,
// bursts (including back-to-back, zero and over-width counts) and reset abort.
module tb_shift_seq_reg;

  logic       clk;
  logic       reset;
  logic [1:0] S;
  logic [1:0] M;
  logic       IL;
  logic       IR;
  logic [7:0] In;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] out;
  logic       so;
  logic       busy;
  logic       done;

  int assertCount;
  int failCount;

  shift_seq_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .S(S), .M(M), .IL(IL), .IR(IR), .In(In),
    .start(start), .cnt(cnt), .out(out), .so(so), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [1:0] m, input logic il, input logic ir,
                               input logic [7:0] din, input logic st, input logic [3:0] c);
    S = s; M = m; IL = il; IR = ir; In = din; start = st; cnt = c;
  endtask

  // Inputs are changed and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [7:0] v);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, v, 1'b0, 4'd0);
    tick();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;

    reset = 1'b0;
    applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
    #1;
    checkOutput("rst_out", out, 8'h00);
    checkOutput("rst_so", so, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    reset = 1'b1;
    tick();
    checkOutput("rel_out", out, 8'h00);
    checkOutput("rel_so", so, 1'b0);
    checkOutput("rel_busy", busy, 1'b0);
    checkOutput("rel_done", done, 1'b0);

    loadValue(8'hA5);
    checkOutput("load_out", out, 8'hA5);
    checkOutput("load_so", so, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b1, 1'b1, 8'h3C, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_out", out, 8'hA5);
      checkOutput("hold_so", so, 1'b0);
    end

    loadValue(8'h81);
    applyStimulus(2'b11, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("rotl_out", out, 8'h03);
    checkOutput("rotl_so", so, 1'b1);

    loadValue(8'h80);
    applyStimulus(2'b10, 2'b11, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("asr_out", out, 8'hC0);
    checkOutput("asr_so", so, 1'b0);

    loadValue(8'h80);
    applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("serl_out", out, 8'h01);
    checkOutput("serl_so", so, 1'b1);

    loadValue(8'h01);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("serr_out", out, 8'h80);
    checkOutput("serr_so", so, 1'b1);

    loadValue(8'h01);
    applyStimulus(2'b11, 2'b01, 1'b1, 1'b1, 8'h00, 1'b1, 4'd3);
    tick();
    checkOutput("b1_start_out", out, 8'h01);
    checkOutput("b1_start_busy", busy, 1'b1);
    checkOutput("b1_start_done", done, 1'b0);
    applyStimulus(2'($urandom), 2'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0, 4'($urandom));
    tick();
    checkOutput("b1_s1_out", out, 8'h02);
    checkOutput("b1_s1_busy", busy, 1'b1);
    checkOutput("b1_s1_done", done, 1'b0);
    applyStimulus(2'($urandom), 2'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0, 4'($urandom));
    tick();
    checkOutput("b1_s2_out", out, 8'h04);
    checkOutput("b1_s2_busy", busy, 1'b1);
    applyStimulus(2'($urandom), 2'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0, 4'($urandom));
    tick();
    checkOutput("b1_s3_out", out, 8'h08);
    checkOutput("b1_s3_busy", busy, 1'b0);
    checkOutput("b1_s3_done", done, 1'b1);
    checkOutput("b1_s3_so", so, 1'b0);

    applyStimulus(2'b10, 2'b01, 1'b1, 1'b1, 8'h00, 1'b1, 4'd2);
    tick();
    checkOutput("b2_start_out", out, 8'h08);
    checkOutput("b2_start_busy", busy, 1'b1);
    checkOutput("b2_start_done", done, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0, 4'd0);
    tick();
    checkOutput("b2_s1_out", out, 8'h04);
    tick();
    checkOutput("b2_s2_out", out, 8'h02);
    checkOutput("b2_s2_done", done, 1'b1);
    checkOutput("b2_s2_busy", busy, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("b2_after_done", done, 1'b0);
    checkOutput("b2_after_out", out, 8'h02);

    applyStimulus(2'b10, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    tick();
    checkOutput("c0_done", done, 1'b1);
    checkOutput("c0_busy", busy, 1'b0);
    checkOutput("c0_out", out, 8'h02);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    tick();
    checkOutput("c0_done_clr", done, 1'b0);

    loadValue(8'h01);
    applyStimulus(2'b11, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 4'd9);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("rot9_busy", busy, 1'b1);
    end
    checkOutput("rot9_mid_out", out, 8'h01);
    tick();
    checkOutput("rot9_out", out, 8'h02);
    checkOutput("rot9_done", done, 1'b1);
    checkOutput("rot9_busy_end", busy, 1'b0);

    loadValue(8'h01);
    applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    tick();
    tick();
    checkOutput("abort_pre_out", out, 8'h04);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_out", out, 8'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort_hold_done", done, 1'b0);
    end
    reset = 1'b1;
    tick();
    checkOutput("abort_rel_done", done, 1'b0);
    checkOutput("abort_rel_busy", busy, 1'b0);
    checkOutput("abort_rel_out", out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
